// File: rtl/sdram_cmd_pkg.sv
// sdram_cmd_pkg: opcodes, parser state encoding and byte classification shared by the UART command parser
package sdram_cmd_pkg;
  localparam logic [7:0] CmdWrite = 8'h77;
  localparam logic [7:0] CmdRead  = 8'h72;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_GET_ADDR = 3'd1;
  localparam state_t S_GET_DATA = 3'd2;
  localparam state_t S_ISSUE_WR = 3'd3;
  localparam state_t S_ISSUE_RD = 3'd4;
  localparam state_t S_WAIT_RD  = 3'd5;
  localparam state_t S_SEND_TX  = 3'd6;
  function automatic logic is_cmd(input logic [7:0] b);
    return b == CmdWrite || b == CmdRead;
  endfunction
endpackage

// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: UART rx/tx, SDRAM request and read-return signals of the command parser
//   master: parser view (consumes rx bytes, issues requests, returns tx bytes)
//   slave : environment view (UART + SDRAM controller)
interface uart_cmd_parser_if #(
  parameter int AddrWidth = 24,
  parameter int DataWidth = 16
);
  logic [7:0]           i_rx_data;
  logic                 i_rx_valid;
  logic                 o_req_valid;
  logic                 o_req_write;
  logic [AddrWidth-1:0] o_req_addr;
  logic [DataWidth-1:0] o_req_wdata;
  logic                 i_req_ready;
  logic                 i_rd_valid;
  logic [DataWidth-1:0] i_rd_data;
  logic [7:0]           o_tx_data;
  logic                 o_tx_valid;
  logic                 i_tx_ready;
  logic                 o_busy;
  logic                 o_err;
  modport master (
    input  i_rx_data, i_rx_valid, i_req_ready, i_rd_valid, i_rd_data, i_tx_ready,
    output o_req_valid, o_req_write, o_req_addr, o_req_wdata, o_tx_data, o_tx_valid, o_busy, o_err
  );
  modport slave (
    output i_rx_data, i_rx_valid, i_req_ready, i_rd_valid, i_rd_data, i_tx_ready,
    input  o_req_valid, o_req_write, o_req_addr, o_req_wdata, o_tx_data, o_tx_valid, o_busy, o_err
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns 'w' addr data / 'r' addr UART byte commands into SDRAM requests, returns read low byte over UART
//   i_sys_clk : system clock
//   i_rst_n   : asynchronous active-low reset
//   bus       : uart_cmd_parser_if.master (rx bytes, SDRAM request/return, tx bytes, busy, err pulse)
module uart_cmd_parser
  import sdram_cmd_pkg::*;
#(
  parameter int AddrWidth     = 24,
  parameter int DataWidth     = 16,
  parameter int TimeoutCycles = 1_330_000
) (
  input logic              i_sys_clk,
  input logic              i_rst_n,
  uart_cmd_parser_if.master bus
);
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  if (AddrWidth < 8) begin : g_addr_chk
    $error("AddrWidth must be at least 8");
  end
  if (DataWidth < 8) begin : g_data_chk
    $error("DataWidth must be at least 8");
  end
  state_t               state_q, state_d;
  logic                 op_wr_q, op_wr_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [7:0]           tx_q, tx_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 rx, counting, expired;
  logic                 unused_rd_hi;
  assign rx       = bus.i_rx_valid;
  assign counting = state_q == S_GET_ADDR || state_q == S_GET_DATA;
  // an rx strobe in the expiry cycle wins over the timeout
  assign expired  = counting && !rx && tmo_q == TmoW'(TimeoutCycles - 1);
  assign unused_rd_hi = ^bus.i_rd_data;
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tx_d    = tx_q;
    err_d   = 1'b0;
    tmo_d   = counting && !rx && !expired ? tmo_q + 1'b1 : '0;
    case (state_q)
      S_IDLE: if (rx) begin
        if (is_cmd(bus.i_rx_data)) begin
          op_wr_d = bus.i_rx_data == CmdWrite;
          state_d = S_GET_ADDR;
        end else err_d = 1'b1;
      end
      S_GET_ADDR: if (rx) begin
        addr_d  = AddrWidth'(bus.i_rx_data);
        state_d = op_wr_q ? S_GET_DATA : S_ISSUE_RD;
      end else if (expired) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_GET_DATA: if (rx) begin
        wdata_d = DataWidth'(bus.i_rx_data);
        state_d = S_ISSUE_WR;
      end else if (expired) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      // in the remaining states an rx byte is an overrun: dropped and flagged, the command carries on
      S_ISSUE_WR: begin
        err_d   = rx;
        state_d = bus.i_req_ready ? S_IDLE : state_q;
      end
      S_ISSUE_RD: begin
        err_d   = rx;
        state_d = bus.i_req_ready ? S_WAIT_RD : state_q;
      end
      S_WAIT_RD: begin
        err_d = rx;
        if (bus.i_rd_valid) begin
          tx_d    = bus.i_rd_data[7:0];
          state_d = S_SEND_TX;
        end
      end
      S_SEND_TX: begin
        err_d   = rx;
        state_d = bus.i_tx_ready ? S_IDLE : state_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tx_q    <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tx_q    <= tx_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end
  assign bus.o_req_valid = state_q == S_ISSUE_WR || state_q == S_ISSUE_RD;
  assign bus.o_req_write = state_q == S_ISSUE_WR;
  assign bus.o_req_addr  = addr_q;
  assign bus.o_req_wdata = wdata_q;
  assign bus.o_tx_valid  = state_q == S_SEND_TX;
  assign bus.o_tx_data   = tx_q;
  assign bus.o_busy      = state_q != S_IDLE;
  assign bus.o_err       = err_q;
endmodule
